// File: rtl/reg_inject_arbiter_if.sv
// Bundles the score-hit handshake, the CPU write request and the register-file
// write port shared between the game logic, the processor and the arbiter.
interface reg_inject_arbiter_if;
    logic        hit_valid;
    logic [2:0]  hit_amount;
    logic        hit_ready;
    logic        cpu_we;
    logic [4:0]  cpu_rd;
    logic [31:0] cpu_data;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;

    modport master (
        output hit_valid, hit_amount, cpu_we, cpu_rd, cpu_data,
        input  hit_ready, rf_we, rf_rd, rf_data
    );

    modport slave (
        input  hit_valid, hit_amount, cpu_we, cpu_rd, cpu_data,
        output hit_ready, rf_we, rf_rd, rf_data
    );
endinterface

// File: rtl/reg_inject_arbiter.sv
// Accumulates score hits and injects the total into register DEST_REG by stealing
// idle CPU write slots; software acknowledges by writing zero to that register.
module reg_inject_arbiter #(
    parameter int unsigned DEST_REG = 30,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    reg_inject_arbiter_if.slave  bus,
    output logic [CNT_W-1:0]     pending,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [4:0]       DEST_RD     = 5'(DEST_REG);
    // Highest pending value that can still absorb a full increment of 7.
    localparam logic [CNT_W-1:0] READY_LIMIT = {CNT_W{1'b1}} - CNT_W'(7);

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   pending_r;
    logic [CNT_W-1:0]   pending_s;
    logic               busy_r;
    logic               hit_ready_r;
    logic               steal_s;
    logic               hit_fire_s;
    logic               ack_s;
    logic [CNT_W-1:0]   hit_ext_s;

    assign hit_fire_s = bus.hit_valid & hit_ready_r;
    assign hit_ext_s  = {{(CNT_W-3){1'b0}}, bus.hit_amount};
    // Only a cycle with no CPU write may be stolen, so CPU traffic is never delayed.
    assign steal_s    = (state_r == ST_ARM) & ~bus.cpu_we;
    assign ack_s      = bus.cpu_we & (bus.cpu_rd == DEST_RD) & (bus.cpu_data == 32'd0);

    // Next-state logic for the injection round.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pending_r != {CNT_W{1'b0}}) state_s = ST_ARM;
                else                            state_s = ST_IDLE;
            end
            ST_ARM: begin
                if (bus.cpu_we) state_s = ST_ARM;
                else            state_s = ST_HOLD;
            end
            ST_HOLD: begin
                if (ack_s) state_s = ST_IDLE;
                else       state_s = ST_HOLD;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Next pending value; a hit landing on the steal cycle seeds the new total.
    always_comb begin
        pending_s = pending_r;
        if (steal_s) begin
            if (hit_fire_s) pending_s = hit_ext_s;
            else            pending_s = {CNT_W{1'b0}};
        end else if (hit_fire_s) begin
            pending_s = pending_r + hit_ext_s;
        end else begin
            pending_s = pending_r;
        end
    end

    // Register-file write mux: CPU pass-through unless this cycle is stolen.
    always_comb begin
        bus.rf_we   = bus.cpu_we;
        bus.rf_rd   = bus.cpu_rd;
        bus.rf_data = bus.cpu_data;
        if (steal_s) begin
            bus.rf_we   = 1'b1;
            bus.rf_rd   = DEST_RD;
            bus.rf_data = {{(32-CNT_W){1'b0}}, pending_r};
        end else begin
            bus.rf_we   = bus.cpu_we;
            bus.rf_rd   = bus.cpu_rd;
            bus.rf_data = bus.cpu_data;
        end
    end

    // State, accumulator and registered status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            pending_r   <= {CNT_W{1'b0}};
            busy_r      <= 1'b0;
            hit_ready_r <= 1'b1;
        end else begin
            state_r     <= state_s;
            pending_r   <= pending_s;
            busy_r      <= (state_s != ST_IDLE);
            hit_ready_r <= (pending_s <= READY_LIMIT);
        end
    end

    assign pending       = pending_r;
    assign busy          = busy_r;
    assign bus.hit_ready = hit_ready_r;

endmodule

// File: tb/tb_reg_inject_arbiter.sv
// Directed bench: expected register-file writes are queued as stimulus is issued
// and a negedge monitor pops and compares every rf_we pulse.
module tb_reg_inject_arbiter;
    logic       clk;
    logic       reset;
    logic [7:0] pending;
    logic       busy;
    int         checks;
    int         errors;
    logic [36:0] exp_q[$];

    reg_inject_arbiter_if bus();

    reg_inject_arbiter #(.DEST_REG(30), .CNT_W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .pending (pending),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic hv, input logic [2:0] ha, input logic we,
                         input logic [4:0] rd, input logic [31:0] d);
        bus.hit_valid  = hv;
        bus.hit_amount = ha;
        bus.cpu_we     = we;
        bus.cpu_rd     = rd;
        bus.cpu_data   = d;
        if (we) exp_q.push_back({rd, d});
    endtask

    task automatic expect_steal(input logic [31:0] val);
        exp_q.push_back({5'd30, val});
    endtask

    task automatic check_status(input string tag, input logic [7:0] p, input logic b, input logic r);
        check({tag, "_pending"}, 64'(pending), 64'(p));
        check({tag, "_busy"}, 64'(busy), 64'(b));
        check({tag, "_hit_ready"}, 64'(bus.hit_ready), 64'(r));
    endtask

    // Monitor: every register-file write must match the head of the queue.
    always @(negedge clk) begin
        logic [36:0] got;
        logic [36:0] want;
        if (bus.rf_we === 1'b1) begin
            got = {bus.rf_rd, bus.rf_data};
            if (exp_q.size() == 0) begin
                check("rf_unexpected_write", 64'(got), 64'h0);
            end else begin
                want = exp_q.pop_front();
                check("rf_write", 64'(got), 64'(want));
            end
        end
    end

    initial begin
        logic [7:0] model_p;
        logic       model_r;
        checks = 0;
        errors = 0;
        reset = 1'b0;
        bus.hit_valid = 1'b0; bus.hit_amount = 3'd0;
        bus.cpu_we = 1'b0; bus.cpu_rd = 5'd0; bus.cpu_data = 32'd0;
        tick();

        // Reset state and pass-through while in reset
        drive(1'b0, 3'd0, 1'b1, 5'd5, 32'hAA);
        #1;
        check("rst_rf_we", 64'(bus.rf_we), 64'd1);
        check("rst_rf_rd", 64'(bus.rf_rd), 64'd5);
        check_status("rst", 8'd0, 1'b0, 1'b1);
        tick();
        reset = 1'b1;
        drive(1'b0, 3'd0, 1'b0, 5'd0, 32'd0);
        tick();
        check_status("idle", 8'd0, 1'b0, 1'b1);

        // Hit 3 then hit 2, then steal of 5
        drive(1'b1, 3'd3, 1'b0, 5'd0, 32'd0);
        tick();
        check_status("hit3", 8'd3, 1'b0, 1'b1);
        drive(1'b1, 3'd2, 1'b0, 5'd0, 32'd0);
        tick();
        check_status("hit2_arm", 8'd5, 1'b1, 1'b1);
        drive(1'b0, 3'd0, 1'b0, 5'd0, 32'd0);
        expect_steal(32'd5);
        #1;
        check("steal_rf_we", 64'(bus.rf_we), 64'd1);
        check("steal_rf_rd", 64'(bus.rf_rd), 64'd30);
        check("steal_rf_data", 64'(bus.rf_data), 64'd5);
        tick();
        check_status("hold", 8'd0, 1'b1, 1'b1);

        // HOLD: nonzero write to DEST is not an ack; hits keep accumulating
        drive(1'b1, 3'd4, 1'b1, 5'd30, 32'd9);
        tick();
        check_status("hold_w9", 8'd4, 1'b1, 1'b1);
        drive(1'b1, 3'd2, 1'b1, 5'd30, 32'd0);
        tick();
        check_status("ack_idle", 8'd6, 1'b0, 1'b1);
        drive(1'b0, 3'd0, 1'b1, 5'd7, 32'h1234);
        tick();
        check_status("rearm", 8'd6, 1'b1, 1'b1);

        // ARM with CPU writes: pass-through, no steal
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 3'd0, 1'b1, 5'd7, 32'h1234);
            #1;
            check("arm_rf_rd", 64'(bus.rf_rd), 64'd7);
            check("arm_rf_data", 64'(bus.rf_data), 64'h1234);
            tick();
            check("arm_busy", 64'(busy), 64'd1);
        end

        // Steal with a simultaneous hit of 4
        drive(1'b1, 3'd4, 1'b0, 5'd0, 32'd0);
        expect_steal(32'd6);
        tick();
        check_status("steal_hit", 8'd4, 1'b1, 1'b1);
        drive(1'b0, 3'd0, 1'b0, 5'd0, 32'd0);
        tick();
        check_status("hold_wait", 8'd4, 1'b1, 1'b1);
        drive(1'b0, 3'd0, 1'b1, 5'd12, 32'd0);
        tick();
        check_status("hold_other", 8'd4, 1'b1, 1'b1);
        drive(1'b1, 3'd2, 1'b1, 5'd30, 32'd0);
        tick();
        check_status("ack2", 8'd6, 1'b0, 1'b1);
        drive(1'b0, 3'd0, 1'b0, 5'd0, 32'd0);
        tick();
        check_status("arm6", 8'd6, 1'b1, 1'b1);

        // Reset mid-steal: aborts the stolen write immediately
        reset = 1'b0;
        #1;
        check("rst_abort_rf_we", 64'(bus.rf_we), 64'd0);
        check_status("rst_mid", 8'd0, 1'b0, 1'b1);
        drive(1'b0, 3'd0, 1'b1, 5'd3, 32'h55);
        #1;
        check("rst_follow_rf_we", 64'(bus.rf_we), 64'd1);
        check("rst_follow_rf_rd", 64'(bus.rf_rd), 64'd3);
        tick();
        reset = 1'b1;
        drive(1'b0, 3'd0, 1'b0, 5'd0, 32'd0);
        tick();
        check_status("post_rst", 8'd0, 1'b0, 1'b1);

        // Continuous hit 7 with no free slot: must stop at 252
        model_p = 8'd0;
        model_r = 1'b1;
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 3'd7, 1'b1, 5'd1, 32'(i));
            tick();
            if (model_r) model_p = model_p + 8'd7;
            model_r = (model_p <= 8'd248);
            check("sat_pending", 64'(pending), 64'(model_p));
            check("sat_ready", 64'(bus.hit_ready), 64'(model_r));
        end
        check_status("sat_end", 8'd252, 1'b1, 1'b0);

        drive(1'b0, 3'd0, 1'b0, 5'd0, 32'd0);
        expect_steal(32'd252);
        #1;
        check("sat_steal_data", 64'(bus.rf_data), 64'd252);
        tick();
        check_status("sat_hold", 8'd0, 1'b1, 1'b1);

        // Only one steal per round before acknowledge
        drive(1'b1, 3'd1, 1'b0, 5'd0, 32'd0);
        tick();
        check_status("one_steal", 8'd1, 1'b1, 1'b1);
        drive(1'b0, 3'd0, 1'b0, 5'd0, 32'd0);
        tick();
        tick();
        check_status("still_hold", 8'd1, 1'b1, 1'b1);

        tick();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
